// File: rtl/fs_accel_ireg_win_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fs_accel_ireg_win_if                                            |
// | Brief    : Column-in / window-out handshake bundle for fs_accel_ireg_win.  |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface fs_accel_ireg_win_if #(
    parameter int DW  = 8,
    parameter int NCH = 3,
    parameter int KW  = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NCH*DW-1:0]        in_data;
    logic                     win_valid;
    logic                     win_ready;
    logic [NCH*KW*DW-1:0]     win_data;
    logic [$clog2(KW+1)-1:0]  fill_level;

    modport master (
        output in_valid, in_data, win_ready,
        input  in_ready, win_valid, win_data, fill_level
    );

    modport slave (
        input  in_valid, in_data, win_ready,
        output in_ready, win_valid, win_data, fill_level
    );
endinterface
`default_nettype wire

// File: rtl/fs_accel_ireg_win.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fs_accel_ireg_win                                               |
// | Brief    : NCH x KW input window shift register with strided emission.     |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module fs_accel_ireg_win #(
    parameter int DW     = 8,
    parameter int NCH    = 3,
    parameter int KW     = 3,
    parameter int STRIDE = 1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           clr,
    fs_accel_ireg_win_if.slave  bus
);
    localparam int c_FW = $clog2(KW + 1);
    localparam int c_SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [c_FW-1:0] c_FULL      = c_FW'(KW);
    localparam logic [c_FW-1:0] c_FILL_LAST = c_FW'(KW - 1);
    localparam logic [c_SW-1:0] c_STR_LAST  = c_SW'(STRIDE - 1);

    logic [NCH*KW*DW-1:0] r_taps;
    logic [c_FW-1:0]      r_fcnt;
    logic [c_SW-1:0]      r_scnt;
    logic                 r_win_valid;

    logic w_in_ready;
    logic w_accept;
    logic w_full;
    logic w_emit;

    // Ready never looks at in_valid, so no combinational in->out path exists.
    assign w_in_ready = !reset && !clr && (!r_win_valid || bus.win_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_full     = (r_fcnt == c_FULL);
    assign w_emit     = w_accept &&
                        ((r_fcnt == c_FILL_LAST) || (w_full && (r_scnt == c_STR_LAST)));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_fcnt      <= '0;
            r_scnt      <= '0;
            r_win_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                if (!w_full) begin
                    r_fcnt <= r_fcnt + c_FW'(1);
                end
                if (w_emit || !w_full) begin
                    r_scnt <= '0;
                end else begin
                    r_scnt <= r_scnt + c_SW'(1);
                end
            end
            // A fresh emit wins over a same-cycle consume of the previous window.
            if (w_emit) begin
                r_win_valid <= 1'b1;
            end else if (r_win_valid && bus.win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    // Each row shifts toward tap 0; the incoming sample lands in tap KW-1.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_taps <= '0;
        end else if (w_accept) begin
            for (int r = 0; r < NCH; r++) begin
                r_taps[r*KW*DW +: KW*DW] <= {bus.in_data[r*DW +: DW],
                                             r_taps[r*KW*DW + DW +: (KW-1)*DW]};
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.win_valid  = r_win_valid;
    assign bus.win_data   = r_taps;
    assign bus.fill_level = r_fcnt;

endmodule
`default_nettype wire

// File: tb/tb_fs_accel_ireg_win.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fs_accel_ireg_win                                            |
// | Brief    : Directed plus random bench for STRIDE=1 and STRIDE=2 instances. |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_fs_accel_ireg_win;
    localparam int DW  = 8;
    localparam int NCH = 3;
    localparam int KW  = 3;
    localparam int CW  = NCH*DW;
    localparam int WW  = NCH*KW*DW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    fs_accel_ireg_win_if #(.DW(DW), .NCH(NCH), .KW(KW)) if_a ();
    fs_accel_ireg_win_if #(.DW(DW), .NCH(NCH), .KW(KW)) if_b ();

    fs_accel_ireg_win #(.DW(DW), .NCH(NCH), .KW(KW), .STRIDE(1)) u_s1 (
        .clk(clk), .reset(reset), .clr(clr), .bus(if_a)
    );
    fs_accel_ireg_win #(.DW(DW), .NCH(NCH), .KW(KW), .STRIDE(2)) u_s2 (
        .clk(clk), .reset(reset), .clr(clr), .bus(if_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Requested stimulus, applied at the next falling edge.
    logic          t_reset = 1'b1;
    logic          t_clr   = 1'b0;
    logic          tv  [2];
    logic          twr [2];
    logic [CW-1:0] tcol[2];

    // Reference model: the accepted-column history since the last flush.
    int            m_n [2];
    logic          m_wv[2];
    logic [CW-1:0] m_hist[2][64];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] col(input int k);
        return {8'(32 + k), 8'(16 + k), 8'(k)};
    endfunction

    // Window = last KW accepted columns, zeros where fewer have arrived.
    function automatic logic [WW-1:0] exp_win(input int d);
        logic [WW-1:0] w;
        int idx;
        w = '0;
        for (int t = 0; t < KW; t++) begin
            idx = m_n[d] - KW + t;
            if (idx >= 0) begin
                for (int r = 0; r < NCH; r++) begin
                    w[(r*KW+t)*DW +: DW] = m_hist[d][idx % 64][r*DW +: DW];
                end
            end
        end
        return w;
    endfunction

    task automatic step();
        logic          g_rdy[2];
        logic          g_wv [2];
        logic [WW-1:0] g_wd [2];
        logic [1:0]    g_fl [2];
        logic          e_rdy;
        logic          acc[2];
        logic          emit;
        int            st;
        @(negedge clk);
        reset = t_reset;
        clr   = t_clr;
        if_a.in_valid = tv[0]; if_a.in_data = tcol[0]; if_a.win_ready = twr[0];
        if_b.in_valid = tv[1]; if_b.in_data = tcol[1]; if_b.win_ready = twr[1];
        #1;
        g_rdy[0] = if_a.in_ready; g_wv[0] = if_a.win_valid;
        g_wd[0]  = if_a.win_data; g_fl[0] = if_a.fill_level;
        g_rdy[1] = if_b.in_ready; g_wv[1] = if_b.win_valid;
        g_wd[1]  = if_b.win_data; g_fl[1] = if_b.fill_level;
        for (int d = 0; d < 2; d++) begin
            e_rdy = !t_reset && !t_clr && (!m_wv[d] || twr[d]);
            chk($sformatf("in_ready[%0d]", d),   128'(g_rdy[d]), 128'(e_rdy));
            chk($sformatf("win_valid[%0d]", d),  128'(g_wv[d]),  128'(m_wv[d]));
            chk($sformatf("win_data[%0d]", d),   128'(g_wd[d]),  128'(exp_win(d)));
            chk($sformatf("fill_level[%0d]", d), 128'(g_fl[d]),
                128'((m_n[d] < KW) ? m_n[d] : KW));
            acc[d] = tv[d] && e_rdy;
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            st = (d == 0) ? 1 : 2;
            if (t_reset || t_clr) begin
                m_n[d]  = 0;
                m_wv[d] = 1'b0;
            end else begin
                emit = 1'b0;
                if (acc[d]) begin
                    m_hist[d][m_n[d] % 64] = tcol[d];
                    m_n[d]++;
                    emit = (m_n[d] >= KW) && (((m_n[d] - KW) % st) == 0);
                end
                if (emit)                     m_wv[d] = 1'b1;
                else if (m_wv[d] && twr[d])   m_wv[d] = 1'b0;
            end
        end
    endtask

    int            nwin;
    logic [WW-1:0] held;

    initial begin
        for (int d = 0; d < 2; d++) begin
            tv[d] = 1'b0; twr[d] = 1'b0; tcol[d] = '0;
            m_n[d] = 0; m_wv[d] = 1'b0;
        end
        if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.win_ready = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.win_ready = 1'b0;

        // Reset for two cycles, then fill with columns 1..3.
        t_reset = 1'b1;
        step(); step();
        t_reset = 1'b0;
        tv[0] = 1'b1; twr[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tcol[0] = col(k);
            step();
        end
        #1;
        chk("fill_valid", 128'(if_a.win_valid), 128'(1));
        chk("fill_row0",  128'(if_a.win_data[23:0]),  128'(24'h030201));
        chk("fill_row2",  128'(if_a.win_data[71:48]), 128'(24'h232221));
        chk("fill_level", 128'(if_a.fill_level), 128'(3));

        // Backpressure: column 4 waits while the window is held.
        held = if_a.win_data;
        twr[0] = 1'b0; tcol[0] = col(4);
        for (int i = 0; i < 5; i++) step();
        #1;
        chk("bp_hold", 128'(if_a.win_data), 128'(held));
        twr[0] = 1'b1;
        step();
        #1;
        chk("bp_row0",  128'(if_a.win_data[23:0]), 128'(24'h040302));
        chk("bp_valid", 128'(if_a.win_valid), 128'(1));

        // Streaming STRIDE=1 after a flush.
        t_clr = 1'b1; tv[0] = 1'b0;
        step();
        t_clr = 1'b0; tv[0] = 1'b1;
        nwin = 0;
        for (int k = 1; k <= 8; k++) begin
            tcol[0] = col(k);
            step();
            #1;
            if (if_a.win_valid) nwin++;
        end
        chk("stream_count", 128'(nwin), 128'(6));
        chk("stream_row1",  128'(if_a.win_data[47:24]), 128'(24'h181716));

        // STRIDE=2 instance: windows only after columns 3, 5, 7.
        tv[0] = 1'b0;
        tv[1] = 1'b1; twr[1] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tcol[1] = col(k);
            step();
            #1;
            chk($sformatf("s2_valid_col%0d", k), 128'(if_b.win_valid),
                128'((k >= 3) && (k % 2 == 1)));
        end
        chk("s2_row0", 128'(if_b.win_data[23:0]), 128'(24'h070605));
        tv[1] = 1'b0;

        // Flush after column 2; the column offered during clr is dropped.
        t_clr = 1'b1;
        step();
        t_clr = 1'b0; tv[0] = 1'b1;
        tcol[0] = col(1); step();
        tcol[0] = col(2); step();
        t_clr = 1'b1; tcol[0] = col(85);
        step();
        t_clr = 1'b0;
        for (int k = 9; k <= 11; k++) begin
            tcol[0] = col(k);
            step();
            #1;
            chk($sformatf("flush_valid_col%0d", k), 128'(if_a.win_valid), 128'(k == 11));
        end
        chk("flush_row0", 128'(if_a.win_data[23:0]), 128'(24'h0B0A09));

        // Reset while a window is held.
        twr[0] = 1'b0; tcol[0] = col(12);
        step();
        t_reset = 1'b1;
        step();
        #1;
        chk("rst_valid", 128'(if_a.win_valid), 128'(0));
        chk("rst_data",  128'(if_a.win_data),  128'(0));
        chk("rst_level", 128'(if_a.fill_level), 128'(0));
        t_reset = 1'b0; tv[0] = 1'b0;
        step();
        #1;
        chk("rst_ready", 128'(if_a.in_ready), 128'(1));

        // Random traffic on both instances with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 2; d++) begin
                tv[d]   = ($urandom_range(0, 3) != 0);
                twr[d]  = ($urandom_range(0, 3) != 0);
                tcol[d] = CW'($urandom);
            end
            t_clr   = ($urandom_range(0, 59) == 0);
            t_reset = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
